// File: rtl/ifu_axi_4_lite_master_pkg.sv
// Shared definitions for the instruction-fetch AXI4-lite read master.
package ifu_axi_4_lite_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] ARPROT_INST = 3'b100;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_axi_4_lite_master.sv
// Instruction-fetch unit: single-outstanding AXI4-lite read master that owns the PC
// and hands fetched instructions to decode over valid/ready.
module ifu_axi_4_lite_master
    import ifu_axi_4_lite_master_pkg::*;
#(
    parameter int unsigned                AXI_DATA_WIDTH = 64,
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  RESET_PC       = AXI_ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    input  logic                      redirect_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [AXI_ADDR_WIDTH-1:0] inst_pc,
    output logic [31:0]               inst,
    output logic                      inst_err,
    output logic [AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
    output logic [2:0]                AXI_ARPROT,
    output logic                      AXI_ARVALID,
    input  logic                      AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0] AXI_RDATA,
    input  logic [1:0]                AXI_RRESP,
    input  logic                      AXI_RVALID,
    output logic                      AXI_RREADY
);

    localparam int unsigned INST_WIDTH = 32;

    ifu_state_e                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                      drop_q, drop_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      rready_q, rready_d;
    logic                      inst_valid_q, inst_valid_d;
    logic [INST_WIDTH-1:0]     inst_q, inst_d;
    logic [AXI_ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                      inst_err_q, inst_err_d;

    logic ar_hs;
    logic r_hs;
    logic accept;

    // Only the low instruction word of the R beat is consumed.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^AXI_RDATA[AXI_DATA_WIDTH-1:INST_WIDTH];

    assign ar_hs  = arvalid_q & AXI_ARREADY;
    assign r_hs   = rready_q & AXI_RVALID;
    assign accept = inst_valid_q & inst_ready;

    // Outputs are registered, so each transition also loads the next state's output values.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_err_d   = inst_err_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        case (state_q)
            IDLE: begin
                state_d   = REQ;
                arvalid_d = 1'b1;
                araddr_d  = pc_d;
            end
            REQ: begin
                // The AR already on the bus must complete; its beat gets dropped.
                if (redirect_valid) begin
                    drop_d = 1'b1;
                end
                if (ar_hs) begin
                    state_d   = WAIT;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            WAIT: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        drop_d    = 1'b0;
                        state_d   = REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = pc_d;
                    end else begin
                        state_d      = HOLD;
                        inst_valid_d = 1'b1;
                        inst_d       = AXI_RDATA[INST_WIDTH-1:0];
                        inst_pc_d    = pc_q;
                        inst_err_d   = (AXI_RRESP != RESP_OKAY);
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                // Redirect kills the held instruction and beats a simultaneous accept.
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                    arvalid_d    = 1'b1;
                    araddr_d     = pc_d;
                end else if (accept) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + AXI_ADDR_WIDTH'(4);
                    state_d      = REQ;
                    arvalid_d    = 1'b1;
                    araddr_d     = pc_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= RESET_PC;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            inst_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
        end
    end

    assign AXI_ARVALID = arvalid_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_ARPROT  = ARPROT_INST;
    assign AXI_RREADY  = rready_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_err    = inst_err_q;

endmodule

// File: tb/tb_ifu_axi_4_lite_master.sv
// Directed bench for the instruction-fetch AXI4-lite read master.
module tb_ifu_axi_4_lite_master;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_err;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    ifu_axi_4_lite_master dut (
        .AXI_ACLK       (clk),
        .AXI_ARESETN    (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .inst_err       (inst_err),
        .AXI_ARADDR     (araddr),
        .AXI_ARPROT     (arprot),
        .AXI_ARVALID    (arvalid),
        .AXI_ARREADY    (arready),
        .AXI_RDATA      (rdata),
        .AXI_RRESP      (rresp),
        .AXI_RVALID     (rvalid),
        .AXI_RREADY     (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed and inputs changed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic ar_hs();
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] r);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = r;
        step();
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({arvalid, rready, inst_valid, inst_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {arvalid, rready, inst_valid, inst_err});
        end
        total++;
        if ({araddr, inst_pc, inst} !== {32'h8000_0000, 32'h8000_0000, 32'h0}) begin
            bad++; $display("FAIL reset_regs: got %h %h %h want 80000000 80000000 00000000", araddr, inst_pc, inst);
        end
        total++;
        if (arprot !== 3'b100) begin
            bad++; $display("FAIL arprot: got %b want 100", arprot);
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({arvalid, rready, araddr} !== {2'b10, 32'h8000_0000}) begin
            bad++; $display("FAIL first_req: got arvalid=%b rready=%b araddr=%h want 1 0 80000000", arvalid, rready, araddr);
        end
    endtask

    task automatic test_basic();
        inst_ready = 1'b1;
        ar_hs();
        total++;
        if ({arvalid, rready, inst_valid} !== 3'b010) begin
            bad++; $display("FAIL basic_wait: got %b want 010", {arvalid, rready, inst_valid});
        end
        r_beat(64'hAAAA_5555_0000_0013, 2'b00);
        total++;
        if ({inst_valid, inst_err, rready, arvalid} !== 4'b1000) begin
            bad++; $display("FAIL basic_valid: got %b want 1000", {inst_valid, inst_err, rready, arvalid});
        end
        total++;
        if ({inst, inst_pc} !== {32'h0000_0013, 32'h8000_0000}) begin
            bad++; $display("FAIL basic_inst: got %h %h want 00000013 80000000", inst, inst_pc);
        end
        step();
        total++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0004}) begin
            bad++; $display("FAIL basic_next: got v=%b arv=%b addr=%h want 0 1 80000004", inst_valid, arvalid, araddr);
        end
    endtask

    task automatic test_decode_stall();
        inst_ready = 1'b0;
        ar_hs();
        r_beat(64'h0000_0000_0000_0093, 2'b00);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({inst_valid, arvalid, rready, inst, inst_pc} !== {3'b100, 32'h0000_0093, 32'h8000_0004}) begin
                bad++; $display("FAIL stall_hold%0d: got v=%b arv=%b rr=%b inst=%h pc=%h want 1 0 0 00000093 80000004",
                                i, inst_valid, arvalid, rready, inst, inst_pc);
            end
            step();
        end
        inst_ready = 1'b1;
        step();
        total++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0008}) begin
            bad++; $display("FAIL stall_next: got v=%b arv=%b addr=%h want 0 1 80000008", inst_valid, arvalid, araddr);
        end
    endtask

    task automatic test_redirect_req();
        inst_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0008}) begin
            bad++; $display("FAIL rreq_hold1: got arv=%b addr=%h want 1 80000008", arvalid, araddr);
        end
        step();
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0008}) begin
            bad++; $display("FAIL rreq_hold2: got arv=%b addr=%h want 1 80000008", arvalid, araddr);
        end
        ar_hs();
        total++;
        if ({arvalid, rready} !== 2'b01) begin
            bad++; $display("FAIL rreq_wait: got %b want 01", {arvalid, rready});
        end
        r_beat(64'h0000_0000_DEAD_BEEF, 2'b00);
        total++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0100}) begin
            bad++; $display("FAIL rreq_drop: got v=%b arv=%b addr=%h want 0 1 80000100", inst_valid, arvalid, araddr);
        end
    endtask

    task automatic test_redirect_r();
        inst_ready = 1'b0;
        ar_hs();
        rvalid         = 1'b1;
        rdata          = 64'h0000_0000_1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        rvalid         = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if ({inst_valid, rready, arvalid, araddr} !== {3'b001, 32'h8000_0200}) begin
            bad++; $display("FAIL rr_drop: got v=%b rr=%b arv=%b addr=%h want 0 0 1 80000200",
                            inst_valid, rready, arvalid, araddr);
        end
        ar_hs();
        r_beat(64'h0000_0000_0000_0033, 2'b00);
        total++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0033, 32'h8000_0200}) begin
            bad++; $display("FAIL rr_next: got v=%b inst=%h pc=%h want 1 00000033 80000200", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_redirect_hold();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        total++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0300}) begin
            bad++; $display("FAIL rh_kill: got v=%b arv=%b addr=%h want 0 1 80000300", inst_valid, arvalid, araddr);
        end
    endtask

    task automatic test_err();
        ar_hs();
        r_beat(64'h1234_5678_CAFE_F00D, 2'b10);
        total++;
        if ({inst_valid, inst_err, inst, inst_pc} !== {2'b11, 32'hCAFE_F00D, 32'h8000_0300}) begin
            bad++; $display("FAIL err_inst: got v=%b e=%b inst=%h pc=%h want 1 1 cafef00d 80000300",
                            inst_valid, inst_err, inst, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0304}) begin
            bad++; $display("FAIL err_next: got v=%b arv=%b addr=%h want 0 1 80000304", inst_valid, arvalid, araddr);
        end
    endtask

    task automatic test_wrap();
        ar_hs();
        r_beat(64'h0, 2'b00);
        total++;
        if ({inst_valid, inst_err, inst_pc} !== {2'b10, 32'h8000_0304}) begin
            bad++; $display("FAIL wrap_ok: got v=%b e=%b pc=%h want 1 0 80000304", inst_valid, inst_err, inst_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_req: got arv=%b addr=%h want 1 fffffffc", arvalid, araddr);
        end
        ar_hs();
        r_beat(64'h0000_0000_0000_0073, 2'b00);
        total++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_inst: got v=%b pc=%h want 1 fffffffc", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'h0000_0000}) begin
            bad++; $display("FAIL wrap_next: got arv=%b addr=%h want 1 00000000", arvalid, araddr);
        end
    endtask

    task automatic test_reset_mid();
        ar_hs();
        total++;
        if (rready !== 1'b1) begin
            bad++; $display("FAIL rstmid_wait: got rready=%b want 1", rready);
        end
        rst_n = 1'b0;
        step();
        total++;
        if ({arvalid, rready, inst_valid, araddr, inst_pc} !== {3'b000, 32'h8000_0000, 32'h8000_0000}) begin
            bad++; $display("FAIL rstmid_regs: got arv=%b rr=%b v=%b addr=%h pc=%h want 0 0 0 80000000 80000000",
                            arvalid, rready, inst_valid, araddr, inst_pc);
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0000}) begin
            bad++; $display("FAIL rstmid_req: got arv=%b addr=%h want 1 80000000", arvalid, araddr);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        arready        = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rvalid         = 1'b0;

        test_reset();
        test_basic();
        test_decode_stall();
        test_redirect_req();
        test_redirect_r();
        test_redirect_hold();
        test_err();
        test_wrap();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
